// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: idle-qualified receiver release, byte FIFO, error counter
module uart_rx_ctrl #(
    parameter int P_FIFO_DEPTH    = 4,
    parameter int P_RST_CYCLES    = 4,
    parameter int P_IDLE_TH       = 160,
    parameter int P_ERR_CNT_WIDTH = 8
) (
    input  logic                              x16_BAUD,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              serial_in,
    input  logic [7:0]                        rx_do,
    input  logic                              rx_valid,
    input  logic                              rx_error,
    output logic                              rx_reset,
    output logic [7:0]                        m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [$clog2(P_FIFO_DEPTH):0]     fifo_level,
    output logic                              overrun,
    input  logic                              clr_count,
    output logic [P_ERR_CNT_WIDTH-1:0]        err_count,
    output logic                              rx_active
);

    localparam int AW     = $clog2(P_FIFO_DEPTH);
    localparam int RST_W  = $clog2(P_RST_CYCLES + 1);
    localparam int IDLE_W = $clog2(P_IDLE_TH + 1);
    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(P_RST_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(P_IDLE_TH - 1);
    localparam logic [AW:0]       LVL_FULL  = (AW+1)'(P_FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_DISABLED,
        S_RESET,
        S_WAIT_IDLE,
        S_RUN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [RST_W-1:0]    rst_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                rx_valid_d;
    logic                err_evt;
    logic [7:0]          mem [P_FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         level;
    logic                full;
    logic                push;
    logic                pop;
    logic                push_ok;

    always_comb begin
        state_nxt = state;
        case (state)
            S_DISABLED:  if (enable) state_nxt = S_RESET;
            S_RESET:     if (rst_cnt == RST_LAST) state_nxt = S_WAIT_IDLE;
            S_WAIT_IDLE: if (serial_in && idle_cnt == IDLE_LAST) state_nxt = S_RUN;
            S_RUN:       if (rx_error) state_nxt = S_RESET;
            default:     state_nxt = S_DISABLED;
        endcase
        // Dropping enable overrides every other transition.
        if (!enable) state_nxt = S_DISABLED;
    end

    always_comb begin
        full    = (level == LVL_FULL);
        m_valid = (level != '0);
        pop     = m_valid && m_ready;
        // An error in the same cycle as a valid edge discards the byte.
        push    = (state == S_RUN) && rx_valid && !rx_valid_d && !rx_error;
        push_ok = push && (!full || pop);
    end

    assign m_data     = mem[rd_ptr];
    assign fifo_level = level;

    always_ff @(posedge x16_BAUD or negedge reset) begin
        if (!reset) begin
            state      <= S_DISABLED;
            rst_cnt    <= '0;
            idle_cnt   <= '0;
            rx_reset   <= 1'b1;
            rx_active  <= 1'b0;
            rx_valid_d <= 1'b0;
            err_evt    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            rst_cnt    <= (state == S_RESET && state_nxt == S_RESET) ? rst_cnt + 1'b1 : '0;
            idle_cnt   <= (state == S_WAIT_IDLE && state_nxt == S_WAIT_IDLE && serial_in)
                          ? idle_cnt + 1'b1 : '0;
            rx_reset   <= (state != S_RUN);
            rx_active  <= (state == S_RUN);
            rx_valid_d <= rx_valid;
            err_evt    <= enable && (state == S_RUN) && rx_error;
            overrun    <= push && full && !pop;
        end
    end

    // Error counting lags the error sample by one cycle so it lines up with rx_reset.
    always_ff @(posedge x16_BAUD or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= err_evt ? P_ERR_CNT_WIDTH'(1) : '0;
        end else if (err_evt && err_count != '1) begin
            err_count <= err_count + 1'b1;
        end
    end

    always_ff @(posedge x16_BAUD or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge x16_BAUD) begin
        if (push_ok) mem[wr_ptr] <= rx_do;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. Holds the receiver in reset until the serial line has been idle long enough, then releases it. Buffers received bytes in a small FIFO behind a valid/ready handshake. On a receiver error it counts the event and re-runs the reset/idle-qualification sequence, so no external intervention is needed. Sits between the UART receiver (its `reset`, `Do`, `valid` and `error` pins) and the byte consumer, in the receiver's `x16_BAUD` domain.

## Interface
- `P_FIFO_DEPTH`, 4: FIFO entries; a power of 2 and at least 2.
- `P_RST_CYCLES`, 4: cycles `rx_reset` is held in S_RESET; at least 1.
- `P_IDLE_TH`, 160: consecutive high `serial_in` samples needed before release (10 bit times at x16); at least 1.
- `P_ERR_CNT_WIDTH`, 8: width of the saturating error counter.
- `x16_BAUD`  in  1  clock, 16× baud rate.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  high = run the receiver; low = hold the receiver in reset.
- `serial_in`  in  1  UART line, monitored for idle; same signal that feeds the receiver.
- `rx_do`  in  8  receiver output byte.
- `rx_valid`  in  1  receiver byte valid; pulse or level, edge-detected.
- `rx_error`  in  1  receiver error state.
- `rx_reset`  out  1  active-high reset to the receiver; registered.
- `m_data`  out  8  FIFO head byte.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  consumer accepts `m_data` when `m_valid && m_ready`.
- `fifo_level`  out  clog2(P_FIFO_DEPTH)+1  current occupancy.
- `overrun`  out  1  one-cycle pulse when a byte is dropped because the FIFO is full.
- `clr_count`  in  1  synchronous clear of `err_count`.
- `err_count`  out  P_ERR_CNT_WIDTH  number of receiver errors, saturating at all-ones.
- `rx_active`  out  1  high while in S_RUN.

## Operation
- **Reset values** (`reset` low): state S_DISABLED, `rx_reset`=1, FIFO empty, `m_valid`=0, `fifo_level`=0, `overrun`=0, `err_count`=0, `rx_active`=0, `rx_valid_d`=0, all counters 0.
- **States:**
  - S_DISABLED: `rx_reset`=1. When `enable`=1, go to S_RESET.
  - S_RESET: `rx_reset`=1 and the cycle counter increments. When it reaches P_RST_CYCLES-1, clear it and go to S_WAIT_IDLE.
  - S_WAIT_IDLE: `rx_reset`=1. The idle counter increments on `serial_in`=1 and clears on `serial_in`=0. When it reaches P_IDLE_TH-1 with `serial_in`=1, go to S_RUN.
  - S_RUN: `rx_reset`=0 and `rx_active`=1. On `rx_error`=1, go to S_RESET and increment `err_count`.
- **Enable:** `enable`=0 in any state goes to S_DISABLED on the next edge and has priority over every other transition. Counters clear on entering S_DISABLED.
- **Byte capture:**
  - `rx_valid_d` registers `rx_valid` every cycle.
  - A push occurs when state is S_RUN, `rx_valid`=1, `rx_valid_d`=0 and `rx_error`=0.
  - `rx_valid` edges in any other state are ignored.
  - `rx_error` and a `rx_valid` edge in the same cycle: the error wins and the byte is discarded.
- **FIFO:**
  - Pop occurs when `m_valid && m_ready`.
  - Push with FIFO full and no pop: the byte is dropped and `overrun` pulses for 1 cycle.
  - Push and pop in the same cycle, FIFO full: both occur and the level stays at P_FIFO_DEPTH.
  - Push and pop in the same cycle, FIFO empty: impossible, since `m_valid`=0.
  - Read and write pointers wrap modulo P_FIFO_DEPTH.
  - FIFO contents survive errors and `enable`=0; only `reset` flushes them.
- **Error counter:**
  - Holds at all-ones.
  - `clr_count` and an increment in the same cycle give 1.
  - `clr_count` alone gives 0.

## Timing
- `rx_reset` is registered and follows the state, so it changes the cycle after the transition edge.
- From `enable` rising to `rx_reset` falling takes 1 + P_RST_CYCLES + P_IDLE_TH cycles, with `serial_in` held high.
- A line glitch low during S_WAIT_IDLE restarts the full P_IDLE_TH count.
- `rx_valid` rising at edge N (sampled): `m_valid`/`fifo_level` update at edge N; `m_data` is valid after edge N.
- `m_data` presents the FIFO head combinationally from storage. It is stable while `m_valid`=1 and `m_ready`=0.
- An `rx_error` sampled at edge N in S_RUN gives `rx_reset`=1 and `rx_active`=0 after edge N+1, and `err_count` incremented after edge N+1.
- Asserting `reset` mid-operation takes effect immediately and asynchronously; deassertion is used synchronously.

## Test plan
- **Bring-up:** release `reset`, `enable`=1, `serial_in`=1, P_RST_CYCLES=4, P_IDLE_TH=160 -> `rx_reset` falls after exactly 165 cycles and `rx_active`=1.
- **Idle glitch:** pull `serial_in` low for 1 cycle at idle count 100 -> release is delayed by 101 cycles versus the clean case.
- **Data path:** drive bytes 0x55, 0xA3, 0x00 as `rx_valid` pulses with `m_ready`=0 -> `fifo_level` reaches 3. Raise `m_ready` -> `m_data` gives 0x55, 0xA3, 0x00 in order, then `m_valid`=0.
- **Overrun:** P_FIFO_DEPTH=4; push 5 bytes (0x01..0x05) with `m_ready`=0 -> `overrun` pulses once on the 5th and the drained data is 0x01..0x04. Repeat with a 5th push coinciding with a pop -> no `overrun` and 0x05 is retained.
- **Error recovery:** assert `rx_error` in S_RUN, together with a `rx_valid` edge carrying 0x7E -> 0x7E is not stored, `err_count`=1, `rx_reset`=1 for P_RST_CYCLES plus the idle wait, then S_RUN resumes. Pulse `clr_count` -> `err_count`=0. Force 260 errors with width 8 -> `err_count`=255.
- **Disable/reset mid-operation:** `enable`=0 during S_WAIT_IDLE -> S_DISABLED next cycle and FIFO contents retained. Assert `reset` with 2 bytes queued -> `fifo_level`=0, `m_valid`=0 and `rx_reset`=1 immediately.
